aes_inv_mix_columns: RTL
========================

// Module: aes_inv_mix_columns
// PURPOSE
//  Iterative AES InvMixColumns engine for the decrypt datapath. It is the inverse of the forward MixColumns xtime (x2) path.
//  Takes a 128-bit state over a valid/ready handshake and multiplies each column by the inverse matrix
//  [0e 0b 0d 09; 09 0e 0b 0d; 0d 09 0e 0b; 0b 0d 09 0e] over GF(2^8), poly 0x11b.
//  Sits between InvShiftRows/InvSubBytes and AddRoundKey in the decryption round loop.
// PARAMETERS
//  COLS_PER_CYCLE  1  columns transformed per clock; legal 1,2,4; busy cycles N = 4/COLS_PER_CYCLE
// PORTS
//  clk        in   1    single clock, rising edge
//  rst_n      in   1    asynchronous, active-low reset
//  in_valid   in   1    in_data valid
//  in_ready   out  1    engine can accept a state
//  in_data    in   128  state; byte k = in_data[127-8k -: 8], column c = bytes 4c..4c+3 (FIPS-197 column-major)
//  out_valid  out  1    out_data valid
//  out_ready  in   1    downstream accepts out_data
//  out_data   out  128  transformed state, same byte order
//  mode       in   1    only with AES_INV_MIXCOL_FWD_EN: 0=inverse, 1=forward MixColumns
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, out_data=0, col_cnt=0.
//  FSM IDLE -> BUSY -> DONE -> IDLE.
//   IDLE: in_ready=1; in_valid&&in_ready -> latch in_data (and mode); col_cnt=0; go to BUSY.
//   BUSY: in_ready=0. Each cycle overwrite columns col_cnt..col_cnt+COLS_PER_CYCLE-1 in place.
//         col_cnt += COLS_PER_CYCLE (2-bit counter, wraps to 0). When the last group is written, go to DONE.
//   DONE: out_valid=1. out_data is held stable while !out_ready.
//         out_ready=1 -> IDLE the next cycle (in_ready rises then; no same-cycle re-accept).
//  Latency: out_valid is asserted N clocks after the accept edge. Throughput: one state per N+2 cycles minimum.
//  out_data is the working register. Its value while out_valid=0 is don't-care for consumers (bench ignores it).
//  GF arithmetic, 8-bit throughout, no carries: xt(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1b : 8'h00).
//   x9=xt3^b; x11=xt3^xt^b; x13=xt3^xt2^b; x14=xt3^xt2^xt.
//  Column out r = XOR over j of M[r][j]*a[j]; row r uses row r of the matrix.
//  in_valid while busy: ignored and not queued; the producer must hold it. in_data is sampled only on the accept edge.
//  out_ready asserted outside DONE: no effect.
//  rst_n low mid-operation: the in-flight state is discarded and there is no output.
//  Reset also returns the FSM to IDLE immediately (async).
// CONFIGURATION
//  AES_INV_MIXCOL_FWD_EN defined: the mode port exists and is latched on accept.
//   mode=1 applies matrix [02 03 01 01; 01 02 03 01; 01 01 02 03; 03 01 01 02], sharing the xt() logic.
//  Not defined: no mode port; inverse transform only; no forward-matrix logic is synthesized.
// STRUCTURE
//  Package aes_gf_pkg: GF_POLY=8'h1b; function xtime(); enum fsm_t {IDLE,BUSY,DONE};
//   byte/column index helper localparams.
//  Sub-module aes_inv_mix_col: combinational 32-bit column transform (plus mode under the macro).
//   Instantiated COLS_PER_CYCLE times in the top.
//  Top: FSM, col_cnt, 128-bit working register, column mux/demux.
// TESTING
//  T1 reset: drive rst_n=0 mid-BUSY -> in_ready=1, out_valid=0, out_data=0 asynchronously; the next accept works normally.
//  T2 vector: in_data=8e4da1bc_9fdc589d_01010101_d5d5d7d6
//     -> out_data=db135345_f20a225c_01010101_d4d4d4d5, out_valid exactly N cycles after accept.
//  T3 backpressure: hold out_ready=0 for 10 cycles in DONE -> out_data stable and in_ready=0 throughout;
//     release -> in_ready=1 the next cycle.
//  T4 busy input: toggle in_valid and in_data during BUSY -> result unchanged vs T2; only one accept counted.
//  T5 fixed points: c6c6c6c6 repeated x4 -> same; 00..00 -> 00..00. Back-to-back stream of 100 random states
//     checked against a reference model, for COLS_PER_CYCLE = 1, 2 and 4.
//  T6 (AES_INV_MIXCOL_FWD_EN) mode=1: db135345_f20a225c_01010101_d4d4d4d5 -> 8e4da1bc_9fdc589d_01010101_d5d5d7d6;
//     fwd then inv round-trips random states.

Source files
------------

// File: rtl/aes_gf_pkg.sv
// GF(2^8) helpers and shared types for the AES InvMixColumns engine.
package aes_gf_pkg;

  localparam logic [7:0] GF_POLY  = 8'h1b;
  localparam int         BYTE_W   = 8;
  localparam int         COL_W    = 32;
  localparam int         NUM_COLS = 4;
  localparam int         NUM_ROWS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_inv_mix_col.sv
// Combinational single-column InvMixColumns; forward MixColumns added when
// AES_INV_MIXCOL_FWD_EN is defined (selected by mode).
module aes_inv_mix_col
  import aes_gf_pkg::*;
(
  input  logic [COL_W-1:0] col_in,
`ifdef AES_INV_MIXCOL_FWD_EN
  input  logic             mode,
`endif
  output logic [COL_W-1:0] col_out
);

  logic [7:0] a   [NUM_ROWS];
  logic [7:0] xt1 [NUM_ROWS];
  logic [7:0] xt2 [NUM_ROWS];
  logic [7:0] xt3 [NUM_ROWS];
  logic [7:0] x9  [NUM_ROWS];
  logic [7:0] x11 [NUM_ROWS];
  logic [7:0] x13 [NUM_ROWS];
  logic [7:0] x14 [NUM_ROWS];
  logic [7:0] inv [NUM_ROWS];
`ifdef AES_INV_MIXCOL_FWD_EN
  logic [7:0] fwd [NUM_ROWS];
`endif

  always_comb begin
    for (int j = 0; j < NUM_ROWS; j++) begin
      a[j]   = col_in[COL_W-1-BYTE_W*j -: BYTE_W];
      xt1[j] = xtime(a[j]);
      xt2[j] = xtime(xt1[j]);
      xt3[j] = xtime(xt2[j]);
      x9[j]  = xt3[j] ^ a[j];
      x11[j] = xt3[j] ^ xt1[j] ^ a[j];
      x13[j] = xt3[j] ^ xt2[j] ^ a[j];
      x14[j] = xt3[j] ^ xt2[j] ^ xt1[j];
    end
  end

  // Each matrix row is the previous one rotated right by one byte.
  always_comb begin
    for (int r = 0; r < NUM_ROWS; r++) begin
      inv[r] = x14[r] ^ x11[(r+1)%4] ^ x13[(r+2)%4] ^ x9[(r+3)%4];
    end
  end

`ifdef AES_INV_MIXCOL_FWD_EN
  always_comb begin
    for (int r = 0; r < NUM_ROWS; r++) begin
      fwd[r] = xt1[r] ^ xt1[(r+1)%4] ^ a[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
    end
  end

  always_comb begin
    col_out = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      col_out[COL_W-1-BYTE_W*r -: BYTE_W] = mode ? fwd[r] : inv[r];
    end
  end
`else
  always_comb begin
    col_out = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      col_out[COL_W-1-BYTE_W*r -: BYTE_W] = inv[r];
    end
  end
`endif

endmodule

// File: rtl/aes_inv_mix_columns.sv
// Iterative AES InvMixColumns engine, COLS_PER_CYCLE columns per clock.
// Optional forward MixColumns via the AES_INV_MIXCOL_FWD_EN macro (adds mode port).
//
// state | meaning
// IDLE  | ready for a new state
// BUSY  | transforming columns in place
// DONE  | result valid, waiting for out_ready
module aes_inv_mix_columns
  import aes_gf_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef AES_INV_MIXCOL_FWD_EN
  input  logic         mode,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] CNT_LAST = 2'(NUM_COLS - COLS_PER_CYCLE);

  fsm_t                          state_q, state_d;
  logic [1:0]                    col_cnt;
  logic [NUM_COLS-1:0][COL_W-1:0] state_reg;
`ifdef AES_INV_MIXCOL_FWD_EN
  logic                          mode_q;
`endif

  logic [1:0]       col_idx [COLS_PER_CYCLE];
  logic [COL_W-1:0] col_in  [COLS_PER_CYCLE];
  logic [COL_W-1:0] col_out [COLS_PER_CYCLE];

  wire accept = (state_q == IDLE) && in_valid;

  // Column 0 sits in the most significant word, so column c is element 3-c.
  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    assign col_idx[g] = col_cnt + 2'(g);
    assign col_in[g]  = state_reg[2'd3 - col_idx[g]];

    aes_inv_mix_col u_col (
      .col_in  (col_in[g]),
`ifdef AES_INV_MIXCOL_FWD_EN
      .mode    (mode_q),
`endif
      .col_out (col_out[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = BUSY;
      BUSY:    if (col_cnt == CNT_LAST) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt   <= 2'd0;
      state_reg <= '0;
`ifdef AES_INV_MIXCOL_FWD_EN
      mode_q    <= 1'b0;
`endif
    end else if (accept) begin
      col_cnt   <= 2'd0;
      state_reg <= in_data;
`ifdef AES_INV_MIXCOL_FWD_EN
      mode_q    <= mode;
`endif
    end else if (state_q == BUSY) begin
      col_cnt <= col_cnt + CNT_STEP;
      for (int g = 0; g < COLS_PER_CYCLE; g++) begin
        state_reg[2'd3 - col_idx[g]] <= col_out[g];
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = state_reg;

endmodule
